memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the byte address width.
REQ-003 The block SHALL have parameter RAM_BASE, default 32'h1001_0000; addresses >= RAM_BASE map to RAM, addresses below map to ROM.
REQ-004 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: if_req_i, input, 1, instruction-fetch request.
REQ-007 Port: if_addr_i, input, ADDR_WIDTH, fetch address.
REQ-008 Port: if_done_o, output, 1, one-cycle fetch completion pulse.
REQ-009 Port: d_req_i, input, 1, data-access request.
REQ-010 Port: d_we_i, input, 1, data write (1) or read (0).
REQ-011 Port: d_addr_i, input, ADDR_WIDTH, data address.
REQ-012 Port: d_wdata_i, input, DATA_WIDTH, write data.
REQ-013 Port: d_done_o, output, 1, one-cycle data completion pulse.
REQ-014 Port: rdata_o, output, DATA_WIDTH, registered read data, valid while a done pulse is high.
REQ-015 Port: err_o, output, 1, error flag, valid while a done pulse is high.
REQ-016 Port: mem_addr_o, output, ADDR_WIDTH, address to the shared memory system.
REQ-017 Port: mem_wdata_o, output, DATA_WIDTH, write data to memory.
REQ-018 Port: mem_we_o, output, 1, memory write enable.
REQ-019 Port: mem_rdata_i, input, DATA_WIDTH, combinational read data from memory.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-021 In IDLE with at least one request high, the block SHALL latch the winner's address, direction and write data, then move to ACCESS.
REQ-022 Single requester: that requester SHALL win.
REQ-023 Both requesting in the same IDLE cycle: the requester not granted last SHALL win (round-robin).
REQ-024 ACCESS SHALL drive mem_addr_o from the latched address; mem_we_o SHALL be 1 for exactly this cycle, and only for a legal data write.
REQ-025 At the end of ACCESS, mem_rdata_i SHALL be captured into rdata_o for reads; on writes rdata_o SHALL hold its previous value.
REQ-026 RESP SHALL pulse the winner's done for one cycle, then return to IDLE.
REQ-027 Latency SHALL be fixed: request sampled in IDLE at cycle N, ACCESS at N+1, done at N+2.
REQ-028 A requester SHALL drop req in the cycle after done; req still high in IDLE is a new request.
REQ-029 A latched address with addr[1:0] != 0 SHALL set err_o, suppress mem_we_o and still complete with done.
REQ-030 A data write to ROM space (address < RAM_BASE) SHALL set err_o, suppress mem_we_o and still complete with done.
REQ-031 Request inputs changing during ACCESS or RESP SHALL be ignored.
REQ-032 Outside ACCESS, mem_addr_o SHALL hold the last latched address and mem_we_o SHALL be 0.

Reset
REQ-033 reset low SHALL immediately force state IDLE and set mem_we_o, if_done_o, d_done_o and err_o to 0.
REQ-034 reset low SHALL immediately clear rdata_o, mem_addr_o and mem_wdata_o to 0.
REQ-035 After reset, the last-grant pointer SHALL be set to data, so fetch wins the first tie.
REQ-036 Reset asserted during ACCESS SHALL drop mem_we_o at once; the aborted access SHALL produce no done pulse.

Verification
REQ-037 Fetch only: if_req_i=1 with if_addr_i=0x0040_0000 and ROM word 0x2008_0005 -> if_done_o at N+2, rdata_o=0x2008_0005, err_o=0.
REQ-038 Data write: d_addr_i=0x1001_0004, d_wdata_i=0xDEAD_BEEF -> mem_we_o=1 for one cycle; a following read of the same address returns 0xDEAD_BEEF.
REQ-039 Simultaneous requests from reset, both held -> grants alternate fetch, data, fetch, with one done every 3 cycles.
REQ-040 Illegal accesses: a write to 0x0040_0010 and a read of 0x1001_0002 -> err_o=1 with done, mem_we_o never asserted.
REQ-041 Reset pulsed low during the ACCESS cycle of a write -> mem_we_o falls immediately, no done pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Round-robin arbiter sharing one memory port between an
//               instruction-fetch requester and a data requester. Every
//               access takes IDLE -> ACCESS -> RESP (done two cycles after
//               the request is sampled). Misaligned accesses and writes to
//               ROM space complete with err_o set and no memory write.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_done_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q,    we_d;
    logic                    grant_q, grant_d;   // 1 = data owns the current access
    logic                    last_q,  last_d;    // 1 = data was granted last
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q,   err_d;

    logic                    w_pick_data;
    logic                    w_err;

    // Access legality is judged on the latched request, so it is stable in ACCESS
    assign w_err = (addr_q[1:0] != 2'b00) || (we_q && (addr_q < RAM_BASE));

    // State and datapath registers; reset clears everything and favours fetch next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, capture result in ACCESS, respond in RESP
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        grant_d     = grant_q;
        last_d      = last_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        w_pick_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    // On a tie the requester not granted last wins
                    w_pick_data = d_req_i && (!if_req_i || !last_q);
                    grant_d     = w_pick_data;
                    last_d      = w_pick_data;
                    addr_d      = w_pick_data ? d_addr_i : if_addr_i;
                    we_d        = w_pick_data && d_we_i;
                    if (w_pick_data) begin
                        wdata_d = d_wdata_i;
                    end
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                err_d = w_err;
                if (!we_q) begin
                    rdata_d = mem_rdata_i;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = (state_q == ACCESS) && we_q && !w_err;
    assign if_done_o   = (state_q == RESP) && !grant_q;
    assign d_done_o    = (state_q == RESP) && grant_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter with a small ROM/RAM
//               model and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_data;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   we_seen  = 0;

    logic [31:0] rom [0:15] = '{0: 32'h2008_0005, 4: 32'hCAFE_0010, default: 32'h0};
    logic [31:0] ram [0:15] = '{default: 32'h0};

    memory_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RAM_BASE  (32'h1001_0000)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_done_o  (if_done),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_done_o   (d_done),
        .rdata_o    (rdata),
        .err_o      (err),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr >= 32'h1001_0000) ? ram[mem_addr[5:2]] : rom[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[5:2]] <= mem_wdata;
            we_seen            <= we_seen + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic issue(input bit is_data, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
    endtask

    // Waits up to 8 cycles for a done pulse; cyc is -1 if none arrived
    task automatic wait_done(input bit hold, output int cyc, output logic got_if, output logic got_d);
        cyc = -1; got_if = 1'b0; got_d = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!hold && k == 1) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            if (if_done || d_done) begin
                cyc = k; got_if = if_done; got_d = d_done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (if_done !== 1'b0) $display("FAIL rst_if_done: got %b expected 0", if_done); else n_pass++;
        n_checks++; if (d_done !== 1'b0) $display("FAIL rst_d_done: got %b expected 0", d_done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", mem_we); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", rdata); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int cyc; logic gi, gd; exp_t e;
        sb.push_back('{is_data: 1'b0, chk_rdata: 1'b1, rdata: 32'h2008_0005, err: 1'b0});
        issue(1'b0, 1'b0, 32'h0040_0000, 32'h0);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2) $display("FAIL fetch_latency: got %0d expected 2", cyc); else n_pass++;
        n_checks++; if (gi !== !e.is_data || gd !== e.is_data) $display("FAIL fetch_owner: got if=%b d=%b expected data=%b", gi, gd, e.is_data); else n_pass++;
        n_checks++; if (rdata !== e.rdata) $display("FAIL fetch_rdata: got %h expected %h", rdata, e.rdata); else n_pass++;
        n_checks++; if (err !== e.err) $display("FAIL fetch_err: got %b expected %b", err, e.err); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_done !== 1'b0) $display("FAIL fetch_pulse_width: got %b expected 0", if_done); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0040_0000) $display("FAIL fetch_addr_hold: got %h expected 00400000", mem_addr); else n_pass++;
    endtask

    task automatic test_write_read();
        int cyc; logic gi, gd; exp_t e; int w0;
        w0 = we_seen;
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b1, rdata: 32'h2008_0005, err: 1'b0});
        issue(1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2 || gd !== 1'b1 || gi !== 1'b0) $display("FAIL write_done: got cyc=%0d if=%b d=%b expected cyc=2 d=1", cyc, gi, gd); else n_pass++;
        n_checks++; if (rdata !== e.rdata) $display("FAIL write_rdata_hold: got %h expected %h", rdata, e.rdata); else n_pass++;
        n_checks++; if (err !== e.err) $display("FAIL write_err: got %b expected %b", err, e.err); else n_pass++;
        n_checks++; if (we_seen - w0 !== 1) $display("FAIL write_we_cycles: got %0d expected 1", we_seen - w0); else n_pass++;
        @(negedge clk);
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
        issue(1'b1, 1'b0, 32'h1001_0004, 32'h0);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2 || gd !== 1'b1) $display("FAIL read_done: got cyc=%0d d=%b expected cyc=2 d=1", cyc, gd); else n_pass++;
        n_checks++; if (rdata !== e.rdata) $display("FAIL read_rdata: got %h expected %h", rdata, e.rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ignore_changes();
        exp_t e; int w0;
        w0 = we_seen;
        sb.push_back('{is_data: 1'b0, chk_rdata: 1'b1, rdata: 32'h2008_0005, err: 1'b0});
        issue(1'b0, 1'b0, 32'h0040_0000, 32'h0);
        @(negedge clk);
        if_addr = 32'h0040_0010;
        issue(1'b1, 1'b1, 32'h1001_000C, 32'h5555_5555);
        n_checks++; if (mem_addr !== 32'h0040_0000) $display("FAIL ignore_addr: got %h expected 00400000", mem_addr); else n_pass++;
        @(negedge clk);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (if_done !== 1'b1 || d_done !== 1'b0) $display("FAIL ignore_owner: got if=%b d=%b expected if=1 d=0", if_done, d_done); else n_pass++;
        n_checks++; if (rdata !== e.rdata) $display("FAIL ignore_rdata: got %h expected %h", rdata, e.rdata); else n_pass++;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (if_done !== 1'b0 || d_done !== 1'b0 || we_seen !== w0) $display("FAIL ignore_idle: got if=%b d=%b we=%0d expected 0 0 0", if_done, d_done, we_seen - w0); else n_pass++;
    endtask

    task automatic test_illegal();
        int cyc; logic gi, gd; exp_t e; int w0;
        w0 = we_seen;
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b0, rdata: 32'h0, err: 1'b1});
        issue(1'b1, 1'b1, 32'h0040_0010, 32'h0BAD_0BAD);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2 || gd !== 1'b1) $display("FAIL rom_write_done: got cyc=%0d d=%b expected cyc=2 d=1", cyc, gd); else n_pass++;
        n_checks++; if (err !== e.err) $display("FAIL rom_write_err: got %b expected %b", err, e.err); else n_pass++;
        @(negedge clk);
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b0, rdata: 32'h0, err: 1'b1});
        issue(1'b1, 1'b0, 32'h1001_0002, 32'h0);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2 || gd !== 1'b1) $display("FAIL misaligned_done: got cyc=%0d d=%b expected cyc=2 d=1", cyc, gd); else n_pass++;
        n_checks++; if (err !== e.err) $display("FAIL misaligned_err: got %b expected %b", err, e.err); else n_pass++;
        n_checks++; if (we_seen !== w0) $display("FAIL illegal_we: got %0d expected 0", we_seen - w0); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_access();
        int cyc; logic gi, gd; exp_t e; int w0; int dones;
        w0 = we_seen; dones = 0;
        issue(1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678);
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) $display("FAIL abort_we_before: got %b expected 1", mem_we); else n_pass++;
        #1 rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL abort_we_drop: got %b expected 0", mem_we); else n_pass++;
        repeat (2) begin
            @(negedge clk);
            if (if_done || d_done) dones++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (if_done || d_done) dones++;
        end
        n_checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else n_pass++;
        n_checks++; if (we_seen !== w0) $display("FAIL abort_no_write: got %0d expected 0", we_seen - w0); else n_pass++;
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b1, rdata: 32'h0, err: 1'b0});
        issue(1'b1, 1'b0, 32'h1001_0008, 32'h0);
        wait_done(1'b0, cyc, gi, gd);
        e = '0; if (sb.size() > 0) e = sb.pop_front();
        n_checks++; if (cyc !== 2 || gd !== 1'b1) $display("FAIL abort_idle_after: got cyc=%0d d=%b expected cyc=2 d=1", cyc, gd); else n_pass++;
        n_checks++; if (rdata !== e.rdata) $display("FAIL abort_ram_untouched: got %h expected %h", rdata, e.rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; logic gi, gd; exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{is_data: 1'b0, chk_rdata: 1'b1, rdata: 32'h2008_0005, err: 1'b0});
        sb.push_back('{is_data: 1'b1, chk_rdata: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
        sb.push_back('{is_data: 1'b0, chk_rdata: 1'b1, rdata: 32'h2008_0005, err: 1'b0});
        issue(1'b0, 1'b0, 32'h0040_0000, 32'h0);
        issue(1'b1, 1'b0, 32'h1001_0004, 32'h0);
        for (int i = 0; i < 3; i++) begin
            wait_done(1'b1, cyc, gi, gd);
            if (i == 2) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            e = '0; if (sb.size() > 0) e = sb.pop_front();
            n_checks++; if (cyc !== ((i == 0) ? 2 : 3)) $display("FAIL rr_spacing_%0d: got %0d expected %0d", i, cyc, (i == 0) ? 2 : 3); else n_pass++;
            n_checks++; if (gd !== e.is_data || gi !== !e.is_data) $display("FAIL rr_order_%0d: got if=%b d=%b expected data=%b", i, gi, gd, e.is_data); else n_pass++;
            n_checks++; if (rdata !== e.rdata) $display("FAIL rr_rdata_%0d: got %h expected %h", i, rdata, e.rdata); else n_pass++;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (if_done !== 1'b0 || d_done !== 1'b0) $display("FAIL rr_quiet: got if=%b d=%b expected 0 0", if_done, d_done); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL sb_empty: got %0d expected 0", sb.size()); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fetch();
        test_write_read();
        test_ignore_changes();
        test_illegal();
        test_reset_in_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
